// File: rtl/block_prefilter_pkg.sv
// Shared types, ASCII constants and byte classification helpers for block_prefilter.
package block_prefilter_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        SPACE = 2'd1,
        WORD  = 2'd2,
        TAIL  = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;

    function automatic logic is_ws(input logic [7:0] b);
        return (b == ASCII_SPACE) || (b == ASCII_TAB) ||
               (b == ASCII_LF)    || (b == ASCII_CR);
    endfunction

    // Only 'A'..'Z' move; punctuation in 0x40..0x5F must stay untouched.
    function automatic logic [7:0] fold_case(input logic [7:0] b);
        if ((b >= 8'h41) && (b <= 8'h5A)) begin
            return b + 8'h20;
        end
        return b;
    endfunction

    // Control codes other than whitespace, plus DEL and everything above.
    function automatic logic is_nonprint(input logic [7:0] b);
        return ((b < ASCII_SPACE) && !is_ws(b)) || (b >= ASCII_DEL);
    endfunction

endpackage

// File: rtl/prefilter_fifo.sv
// DEPTH x 8 synchronous FIFO; extra pointer bit separates full from empty.
module prefilter_fifo
    import block_prefilter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_wr;
    logic        do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    // Drive zero when empty so nothing stale is visible after reset.
    assign rd_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    // Pointer update; simultaneous read and write leave occupancy unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, cleared on reset so a mid-stream reset leaves no residue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/block_prefilter.sv
// Byte-stream normaliser ahead of block_checker: case fold, whitespace
// collapse, guaranteed leading/trailing space, word counting.
// Optional build macro DROP_NONPRINT_EN discards non-printable bytes.
//
// state | meaning
// START | emit the stream-leading space, no input taken
// SPACE | last emitted byte was a space; whitespace is swallowed
// WORD  | inside a word; whitespace emits one space
// TAIL  | stream ended mid-word; emit the trailing space
module block_prefilter
    import block_prefilter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] word_count,
    output logic             busy
);

    state_t     state;
    state_t     state_nxt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       word_inc;
    logic       accept;
    logic       byte_ws;
    logic       byte_drop;

    assign byte_ws = is_ws(in_data);
`ifdef DROP_NONPRINT_EN
    assign byte_drop = is_nonprint(in_data);
`else
    assign byte_drop = 1'b0;
`endif

    assign in_ready  = ((state == SPACE) || (state == WORD)) && !fifo_full;
    assign accept    = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign busy      = !fifo_empty || (state != SPACE);

    prefilter_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= START;
        else        state <= state_nxt;
    end

    // Next state and FIFO write; at most one write per cycle.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_data   = ASCII_SPACE;
        word_inc  = 1'b0;
        case (state)
            START: begin
                if (!fifo_full) begin
                    wr_en     = 1'b1;
                    state_nxt = SPACE;
                end
            end
            SPACE: begin
                // Whitespace, dropped bytes and a bare in_last all leave us here.
                if (accept && !byte_drop && !byte_ws) begin
                    wr_en     = 1'b1;
                    wr_data   = fold_case(in_data);
                    word_inc  = 1'b1;
                    state_nxt = in_last ? TAIL : WORD;
                end
            end
            WORD: begin
                if (accept) begin
                    if (byte_drop) begin
                        // A dropped final byte still closes the word.
                        if (in_last) begin
                            wr_en     = 1'b1;
                            state_nxt = SPACE;
                        end
                    end else if (byte_ws) begin
                        wr_en     = 1'b1;
                        state_nxt = SPACE;
                    end else begin
                        wr_en     = 1'b1;
                        wr_data   = fold_case(in_data);
                        state_nxt = in_last ? TAIL : WORD;
                    end
                end
            end
            TAIL: begin
                if (!fifo_full) begin
                    wr_en     = 1'b1;
                    state_nxt = SPACE;
                end
            end
            default: state_nxt = START;
        endcase
    end

    // Saturating word counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count <= '0;
        end else if (word_inc && (word_count != {CNT_W{1'b1}})) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_block_prefilter.sv
// Directed scoreboard bench for block_prefilter.
module tb_block_prefilter;

    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [CNT_W-1:0] word_count;
    logic             busy;

    int         vectors;
    int         miscompares;
    logic [7:0] exp_q [$];
    logic [7:0] prev_out;
    logic       prev_valid;

    block_prefilter #(.DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .word_count (word_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every transfer, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $error("FAIL unexpected_out observed=%0h expected=none", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                assert (out_data === e) else begin
                    miscompares++;
                    $error("FAIL out_data observed=%0h expected=%0h", out_data, e);
                end
            end
            if (prev_valid && prev_out == 8'h20) begin
                vectors++;
                assert (out_data !== 8'h20) else begin
                    miscompares++;
                    $error("FAIL double_space observed=%0h expected=non-20", out_data);
                end
            end
            prev_out   = out_data;
            prev_valid = 1'b1;
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                vectors++;
                miscompares++;
                $error("FAIL send_timeout observed=stalled expected=accept byte %0h", b);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last_on_end);
        for (int i = 0; i < s.len(); i++)
            send(s[i], last_on_end && (i == s.len() - 1));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
            n++;
            if (n > 300) break;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_busy"}, busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        exp_q.delete();
        prev_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        prev_valid  = 1'b0;
        prev_out    = 8'h00;
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        in_last     = 1'b0;
        out_ready   = 1'b1;

        // 1: reset state, then a lone leading space.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,   1'b0);
        check("rst_out_valid", out_valid,  1'b0);
        check("rst_out_data",  out_data,   8'h00);
        check("rst_word_count", word_count, 0);
        push_str(" ");
        reset = 1'b1;
        drain("t1");
        check("t1_word_count", word_count, 0);

        // 2: case fold and whitespace collapse.
        push_str("begin x end ");
        send_str("BEGIN  x\tEnd", 1'b1);
        drain("t2");
        check("t2_word_count", word_count, 3);

        // 3: backpressure fills the FIFO, then drains without loss.
        apply_reset();
        out_ready = 1'b0;
        push_str(" abcdef ");
        #1;
        reset = 1'b1;
        send("a", 1'b0);
        send("b", 1'b0);
        send("c", 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_in_ready_full", in_ready,  1'b0);
            check("t3_out_valid",     out_valid, 1'b1);
            check("t3_out_data_hold", out_data,  8'h20);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_str("def", 1'b1);
        drain("t3");
        check("t3_word_count", word_count, 1);

        // 4: reset mid-stream discards buffered bytes.
        out_ready = 1'b0;
        send_str("hel", 1'b0);
        @(negedge clk);
        check("t4_pre_word_count", word_count, 2);
        check("t4_pre_out_valid",  out_valid,  1'b1);
        apply_reset();
        check("t4_rst_out_valid",  out_valid,  1'b0);
        check("t4_rst_word_count", word_count, 0);
        check("t4_rst_in_ready",   in_ready,   1'b0);
        push_str(" ");
        out_ready = 1'b1;
        reset     = 1'b1;
        drain("t4");

        // 5: in_last on whitespace adds nothing; next stream has no doubled space.
        push_str("end ");
        send_str("end ", 1'b1);
        push_str("begin ");
        send_str("begin", 1'b1);
        drain("t5");
        check("t5_word_count", word_count, 2);

        // 6: non-printable bytes, dropped or passed depending on the build.
`ifdef DROP_NONPRINT_EN
        push_str("ab ");
`else
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h62);
        exp_q.push_back(8'h7F);
        exp_q.push_back(8'h20);
`endif
        send(8'h61, 1'b0);
        send(8'h01, 1'b0);
        send(8'h62, 1'b0);
        send(8'h7F, 1'b1);
        drain("t6");
        check("t6_word_count", word_count, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/block_prefilter.md
Name: block_prefilter

Overview:
Upstream stage of block_checker. Accepts a raw ASCII byte stream with a valid/ready handshake and normalises it before block_checker sees it.
- Folds upper-case letters to lower case.
- Collapses whitespace runs to a single space.
- Guarantees a leading space at stream start and a trailing space at stream end, so " begin" / " end" always have token boundaries.
- Buffers output in a small FIFO and counts words.

Parameters:
DEPTH, 4, output FIFO entries; power of 2, minimum 2
CNT_W, 16, width of word_count

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  in_data/in_last valid
in_ready  out  1  block accepts byte this cycle
in_data  in  8  raw ASCII byte
in_last  in  1  in_data is final byte of current stream
out_valid  out  1  out_data valid
out_ready  in  1  consumer takes out_data this cycle
out_data  out  8  normalised byte
word_count  out  CNT_W  words emitted since reset, saturating
busy  out  1  FIFO non-empty or state != SPACE

Behaviour:
Reset (reset=0, async):
- FIFO emptied; out_valid=0, out_data=0, word_count=0, state=START.
- in_ready=0 while reset is asserted.
- Reset mid-stream discards all buffered bytes; no partial output survives.

Classification:
- ws = 0x20, 0x09, 0x0A, 0x0D.
- 'A'..'Z' fold to +0x20. All other bytes pass unchanged; no blanket OR-0x20.

Handshakes:
- Input accepted when in_valid && in_ready.
- in_ready = (state==SPACE || state==WORD) && !fifo_full. It depends on the registered full flag only, with no same-cycle pass-through from out_ready.
- Output transfer when out_valid && out_ready.
- out_data/out_valid are held stable while out_valid && !out_ready.

FSM (one FIFO write per cycle maximum):
- START: when !full, write 0x20 -> SPACE. No input consumed. Entered only from reset.
- SPACE:
  - accept ws -> no write; stay SPACE.
  - accept non-ws -> write folded char, word_count++ -> WORD.
  - in_last in SPACE -> stay SPACE; no extra byte.
- WORD:
  - accept non-ws -> write folded char; stay WORD.
  - accept ws -> write 0x20 -> SPACE.
  - in_last on non-ws -> write char -> TAIL.
  - in_last on ws -> write 0x20 -> SPACE.
- TAIL: in_ready=0; when !full, write 0x20 -> SPACE.
- Consequence: output never contains two consecutive 0x20. The next stream continues from SPACE without a duplicate leading space.

Latency and boundaries:
- Latency: accepted byte appears at out_valid the next cycle if the FIFO was empty.
- FIFO read and write in the same cycle are both performed; occupancy is unchanged.
- Full: in_ready=0, and START/TAIL writes stall.
- Empty: out_valid=0.
- FIFO pointers wrap modulo DEPTH using an extra pointer bit for the full/empty distinction.
- word_count saturates at 2^CNT_W-1 and never wraps.

Optional Feature:
DROP_NONPRINT_EN
- Defined: accepted bytes <0x20 that are not ws, and bytes >=0x7F, are consumed with no write and no state change. If such a byte carries in_last, in_last is processed as if the byte were ws: WORD -> TAIL-equivalent trailing space, SPACE -> stay.
- Undefined: such bytes are treated as ordinary non-ws characters.

Decomposition:
- Package block_prefilter_pkg:
  - state encoding: START, SPACE, WORD, TAIL
  - ASCII_SPACE, ASCII_TAB, ASCII_LF, ASCII_CR
  - is_ws / fold_case functions
- One sub-module: prefilter_fifo (parameterised DEPTH×8 synchronous FIFO, full/empty flags, async active-low reset).

Test Plan:
- Reset release, out_ready=1, no input -> exactly one byte 0x20 emitted; busy falls; word_count=0.
- Send "BEGIN  x\tEnd" with in_last on 'd', out_ready=1 -> output " begin x end " (single spaces, trailing 0x20); word_count=3.
- out_ready=0 with DEPTH=4, stream "abcdef" -> 4 bytes buffered (' ','a','b','c'); in_ready=0; out_data holds 0x20. Then release -> "abcdef" drains in order, no loss.
- Reset asserted after 3 bytes of "hello" -> out_valid=0 immediately, word_count=0. After release, output starts again with 0x20.
- in_last on a space after "end" -> no extra trailing byte; output " end ". A second stream "begin" yields "begin " with no doubled space.
- With DROP_NONPRINT_EN, stream "a\x01b\x7F" + in_last -> " ab ". Without the macro -> " a\x01b\x7F ".
